// File: rtl/cnt10_ctrl.sv
// rtl/cnt10_ctrl.sv - command-driven sequencer for one external cnt10 decade counter
//
// Presets the counter (LOAD), runs it for a programmed number of carry-outs
// or free-running (RUN), stops it (STOP) and pulses done on completion.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready command handshake; cmd_op 00 NOP, 01 LOAD, 10 RUN, 11 STOP
//   cmd_data        preset value for LOAD
//   cmd_wraps       wrap target for RUN (0 = free-run)
//   cnt_en/load/data  drive the cnt10 datapath
//   cnt_cout        cnt10 carry (dout==9 and enabled)
//   cnt_dout        cnt10 value, observed only
//   busy            high in LOAD, RUN and DONE
//   done            one-cycle pulse when the wrap target is reached
//   wrap_cnt        carries counted in the current or last RUN
//   err             sticky protocol-error flag
module cnt10_ctrl #(
  parameter int WRAP_W    = 8,
  parameter int DIGIT_MAX = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_data,
  input  logic [WRAP_W-1:0] cmd_wraps,
  output logic              cnt_en,
  output logic              cnt_load,
  output logic [3:0]        cnt_data,
  input  logic              cnt_cout,
  input  logic [3:0]        cnt_dout,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_STOP = 2'b11;

  localparam logic [3:0] DIGIT_MAX_L = 4'(DIGIT_MAX);

  logic [1:0]        state_q, state_d;
  logic              cnt_en_q, cnt_en_d;
  logic              cnt_load_q, cnt_load_d;
  logic [3:0]        cnt_data_q, cnt_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              err_q, err_d;
  logic [WRAP_W-1:0] target_q, target_d;

  logic              cmd_acc;
  logic              carry;
  logic [WRAP_W-1:0] wrap_inc;

  // cnt_dout is observed only; control decisions use the carry alone.
  logic unused_dout;
  assign unused_dout = ^cnt_dout;

  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign carry     = cnt_cout && cnt_en_q;
  // Saturate rather than wrap so a long free-run never reports a small count.
  assign wrap_inc  = (&wrap_cnt_q) ? wrap_cnt_q : wrap_cnt_q + WRAP_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_en_d   = cnt_en_q;
    cnt_load_d = 1'b0;
    cnt_data_d = cnt_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    err_d      = err_q;
    target_d   = target_q;

    case (state_q)
      ST_IDLE: begin
        cnt_en_d = 1'b0;
        busy_d   = 1'b0;
        if (cmd_acc) begin
          case (cmd_op)
            OP_LOAD: begin
              if (cmd_data <= DIGIT_MAX_L) begin
                cnt_data_d = cmd_data;
                cnt_load_d = 1'b1;
                cnt_en_d   = 1'b1;
                busy_d     = 1'b1;
                state_d    = ST_LOAD;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_RUN: begin
              target_d   = cmd_wraps;
              wrap_cnt_d = '0;
              cnt_en_d   = 1'b1;
              busy_d     = 1'b1;
              state_d    = ST_RUN;
            end
            default: ;
          endcase
        end
      end

      ST_LOAD: begin
        cnt_en_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end

      ST_RUN: begin
        if (carry) begin
          wrap_cnt_d = wrap_inc;
        end
        // Reaching the target wins over a STOP on the same edge.
        if (carry && (target_q != '0) && (wrap_inc == target_q)) begin
          cnt_en_d = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else if (cmd_acc && (cmd_op == OP_STOP)) begin
          cnt_en_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
        if (cmd_acc && ((cmd_op == OP_LOAD) || (cmd_op == OP_RUN))) begin
          err_d = 1'b1;
        end
      end

      ST_DONE: begin
        cnt_en_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        cnt_en_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_en_q   <= 1'b0;
      cnt_load_q <= 1'b0;
      cnt_data_q <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrap_cnt_q <= '0;
      err_q      <= 1'b0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_en_q   <= cnt_en_d;
      cnt_load_q <= cnt_load_d;
      cnt_data_q <= cnt_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_q      <= err_d;
      target_q   <= target_d;
    end
  end

  assign cnt_en   = cnt_en_q;
  assign cnt_load = cnt_load_q;
  assign cnt_data = cnt_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wrap_cnt = wrap_cnt_q;
  assign err      = err_q;

endmodule
